stack_lifo: RTL and testbench



---
 rtl/stack_pkg.sv | 18 +
 rtl/stack_ram.sv | 28 ++
 rtl/stack_lifo.sv | 138 +++++++++++++
 tb/tb_stack_lifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and operation encoding for the hardware return/data stack.
// The top level takes its parameter defaults from here.
package stack_pkg;

  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int PC_W  = 12;
  localparam int SP_W  = $clog2(DEPTH) + 1;

  // Encoding matches the {push, pop} control pair so it can be cast directly.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH stack storage: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module stack_ram
  import stack_pkg::*;
#(
  parameter int DEPTH = stack_pkg::DEPTH,
  parameter int WIDTH = stack_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Entry write on the push edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/stack_lifo.sv
// Hardware return/data stack: sp counter, push/pop decode, registered pop
// port and sticky overflow/underflow flags. Storage lives in stack_ram.
module stack_lifo
  import stack_pkg::*;
#(
  parameter int DEPTH = stack_pkg::DEPTH,
  parameter int WIDTH = stack_pkg::WIDTH,
  parameter int PC_W  = stack_pkg::PC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           stack_in,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       pop_valid,
  output logic [PC_W-1:0]            ret_pc,
  output logic [WIDTH-1:0]           stack_top,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SPW  = AW + 1;

  logic [SPW-1:0]   sp_r;
  logic [SPW-1:0]   sp_nxt_s;
  logic [WIDTH-1:0] pop_data_r;
  logic [WIDTH-1:0] pop_data_nxt_s;
  logic             pop_valid_r;
  logic             pop_valid_nxt_s;
  logic             ovf_r;
  logic             unf_r;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [AW-1:0]    top_addr_s;
  logic [WIDTH-1:0] rd_data_s;
  logic             full_s;
  logic             empty_s;
  stack_op_e        op_s;

  assign full_s     = (sp_r == SPW'(DEPTH));
  assign empty_s    = (sp_r == {SPW{1'b0}});
  assign top_addr_s = AW'(sp_r - SPW'(1));
  assign op_s       = stack_op_e'({push, pop});

  stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (stack_in),
    .raddr (top_addr_s),
    .rdata (rd_data_s)
  );

  // Push/pop decode; only control inputs and sp steer state, never stack_in.
  always_comb begin
    sp_nxt_s        = sp_r;
    pop_data_nxt_s  = pop_data_r;
    pop_valid_nxt_s = 1'b0;
    we_s            = 1'b0;
    waddr_s         = sp_r[AW-1:0];
    ovf_set_s       = 1'b0;
    unf_set_s       = 1'b0;
    case (op_s)
      OP_PUSH: begin
        if (!full_s) begin
          we_s     = 1'b1;
          sp_nxt_s = sp_r + SPW'(1);
        end else begin
          ovf_set_s = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty_s) begin
          pop_data_nxt_s  = rd_data_s;
          pop_valid_nxt_s = 1'b1;
          sp_nxt_s        = sp_r - SPW'(1);
        end else begin
          unf_set_s = 1'b1;
        end
      end
      OP_REPL: begin
        if (!empty_s) begin
          // Replace-top: old top leaves via pop_data, new value overwrites it.
          pop_data_nxt_s  = rd_data_s;
          pop_valid_nxt_s = 1'b1;
          we_s            = 1'b1;
          waddr_s         = top_addr_s;
        end else begin
          we_s      = 1'b1;
          sp_nxt_s  = SPW'(1);
          unf_set_s = 1'b1;
        end
      end
      default: begin
        sp_nxt_s = sp_r;
      end
    endcase
  end

  // State registers; a new error outranks a same-cycle err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r        <= {SPW{1'b0}};
      pop_data_r  <= {WIDTH{1'b0}};
      pop_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      sp_r        <= sp_nxt_s;
      pop_data_r  <= pop_data_nxt_s;
      pop_valid_r <= pop_valid_nxt_s;
      ovf_r       <= (ovf_r & ~err_clr) | ovf_set_s;
      unf_r       <= (unf_r & ~err_clr) | unf_set_s;
    end
  end

  assign pop_data  = pop_data_r;
  assign pop_valid = pop_valid_r;
  assign ret_pc    = pop_data_r[PC_W-1:0];
  assign stack_top = empty_s ? {WIDTH{1'b0}} : rd_data_s;
  assign sp        = sp_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign ovf       = ovf_r;
  assign unf       = unf_r;

endmodule

// File: tb/tb_stack_lifo.sv
// Scoreboard bench for stack_lifo: stimulus queues expected pops, a negedge
// monitor compares each pop_valid strobe; status is checked inline.
module tb_stack_lifo;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic        pop;
  logic [15:0] stack_in;
  logic        err_clr;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic [11:0] ret_pc;
  logic [15:0] stack_top;
  logic [4:0]  sp;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        unf;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb_q [$];

  stack_lifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .stack_in  (stack_in),
    .err_clr   (err_clr),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .ret_pc    (ret_pc),
    .stack_top (stack_top),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of control; returns 1 time unit after the active edge.
  task automatic step(input logic ps, input logic pp, input logic [15:0] d, input logic clr);
    push = ps; pop = pp; stack_in = d; err_clr = clr;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; stack_in = 16'h0000; err_clr = 1'b0;
  endtask

  task automatic fill16(input logic [15:0] base);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, base + 16'(i), 1'b0);
  endtask

  // Monitor: every pop_valid strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && pop_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got 0x%0h expected no strobe", pop_data);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        chk("pop_data", 32'(pop_data), 32'(e));
        chk("ret_pc", 32'(ret_pc), 32'(e[11:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; stack_in = 16'h0000; err_clr = 1'b0;
    #12;
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_flags", 32'({ovf, unf, pop_valid}), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_top", 32'(stack_top), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic LIFO order with back-to-back pops
    step(1'b1, 1'b0, 16'h1234, 1'b0);
    chk("top_after_push", 32'(stack_top), 32'h1234);
    step(1'b1, 1'b0, 16'h0ABC, 1'b0);
    step(1'b1, 1'b0, 16'hFFFF, 1'b0);
    chk("sp3", 32'(sp), 32'd3);
    chk("top3", 32'(stack_top), 32'hFFFF);
    sb_q.push_back(16'hFFFF); sb_q.push_back(16'h0ABC); sb_q.push_back(16'h1234);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("empty_after_pops", 32'(empty), 32'd1);
    #6;

    // Full and overflow
    fill16(16'h0100);
    chk("full", 32'(full), 32'd1);
    chk("sp16", 32'(sp), 32'd16);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("sp16_after_ovf", 32'(sp), 32'd16);
    chk("top_not_dead", 32'(stack_top), 32'h010F);
    for (int i = 15; i >= 0; i--) sb_q.push_back(16'h0100 + 16'(i));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("empty_after_drain", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Underflow and clear priority
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("unf_set", 32'(unf), 32'd1);
    chk("unf_no_valid", 32'(pop_valid), 32'd0);
    chk("unf_sp", 32'(sp), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("unf_cleared", 32'(unf), 32'd0);
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    chk("unf_set_wins", 32'(unf), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);

    // Replace-top
    step(1'b1, 1'b0, 16'h0011, 1'b0);
    step(1'b1, 1'b0, 16'h0022, 1'b0);
    step(1'b1, 1'b0, 16'h0033, 1'b0);
    sb_q.push_back(16'h0033);
    step(1'b1, 1'b1, 16'h7777, 1'b0);
    chk("repl_sp", 32'(sp), 32'd3);
    chk("repl_top", 32'(stack_top), 32'h7777);
    sb_q.push_back(16'h7777); sb_q.push_back(16'h0022); sb_q.push_back(16'h0011);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);

    // Replace-top while full does not overflow
    fill16(16'h0200);
    sb_q.push_back(16'h020F);
    step(1'b1, 1'b1, 16'h0AAA, 1'b0);
    chk("repl_full_ovf", 32'(ovf), 32'd0);
    chk("repl_full_sp", 32'(sp), 32'd16);
    chk("repl_full_top", 32'(stack_top), 32'h0AAA);
    sb_q.push_back(16'h0AAA);
    for (int i = 14; i >= 0; i--) sb_q.push_back(16'h0200 + 16'(i));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0000, 1'b0);

    // Push and pop together while empty
    step(1'b1, 1'b1, 16'h0042, 1'b0);
    chk("pp_empty_sp", 32'(sp), 32'd1);
    chk("pp_empty_top", 32'(stack_top), 32'h0042);
    chk("pp_empty_unf", 32'(unf), 32'd1);
    chk("pp_empty_valid", 32'(pop_valid), 32'd0);
    sb_q.push_back(16'h0042);
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    chk("pp_unf_clr", 32'(unf), 32'd0);

    // Asynchronous reset mid-operation drops an in-flight strobe
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0500 + 16'(i), 1'b0);
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("pre_rst_valid", 32'(pop_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_sp", 32'(sp), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_valid", 32'(pop_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    chk("post_rst_unf", 32'(unf), 32'd1);
    chk("post_rst_valid", 32'(pop_valid), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
